muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
Controller that sequences the shared multiply and divide units and owns the HI/LO write port.
- Accepts one operation request from control_unit and latches the operands.
- Launches the mult or div unit and waits for its completion flag.
- Writes results into HI/LO and reports done, divide-by-zero or timeout.
- Sits between control_unit and the mult/div units; replaces the direct HI_w/LO_w and DivOp/mult_control drive.

Parameters:
TIMEOUT_CYCLES, 64, max RUN-state cycles before abort (used only with MULDIV_TIMEOUT_EN)
CNT_W, 7, width of the run-cycle counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse from control_unit; sampled only in IDLE
op  in  1  0 = MULT, 1 = DIV; latched with start
a_in  in  32  operand A (register A output); latched with start
b_in  in  32  operand B (register B output); latched with start
mult_start  out  1  one-cycle launch pulse to mult unit
mult_end  in  1  mult unit completion flag
mult_hi  in  32  mult result, high word
mult_lo  in  32  mult result, low word
div_start  out  1  one-cycle launch pulse to div unit
div_done  in  1  div unit completion flag
div_quot  in  32  quotient
div_rem  in  32  remainder
unit_reset  out  1  one-cycle clear pulse to div/mult on abort
hi_data  out  32  data to HI register
lo_data  out  32  data to LO register
hi_w  out  1  HI write enable
lo_w  out  1  LO write enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
div_zero  out  1  one-cycle divide-by-zero flag, coincident with done
timeout  out  1  one-cycle watchdog flag, coincident with done

Behaviour:
- States: IDLE, CHECK, RUN, WRITE, DONE, ERR. Moore outputs, all registered state.
- Reset (also mid-operation): state goes to IDLE, counter goes to 0, and every output is 0 on the next cycle. hi_data and lo_data clear to 0. No HI/LO write occurs on reset.
- IDLE: on start=1, latch op, a_in and b_in, then go to CHECK. A start seen in any other state is ignored, with no queueing.
- CHECK, lasting exactly one cycle:
  - If op=DIV and latched B==0, go to ERR; div_start is not asserted.
  - Otherwise assert mult_start (op=0) or div_start (op=1) during this cycle, clear the counter, and go to RUN.
- RUN: counter increments each cycle and saturates at its maximum.
  - For op=0, exit on mult_end=1: capture hi_data<=mult_hi and lo_data<=mult_lo.
  - For op=1, exit on div_done=1: capture hi_data<=div_rem and lo_data<=div_quot.
  - After capture, go to WRITE.
  - The completion flag of the unit not selected by op is ignored.
- WRITE: hi_w=lo_w=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. A start in this cycle is ignored.
- ERR: done=1 and unit_reset=1 for one cycle, then go to IDLE.
  - div_zero=1 if entered from CHECK; timeout=1 if entered from RUN by the watchdog.
  - hi_w/lo_w stay 0, so HI/LO keep their old values.
- Latency:
  - A start sampled at edge 0 gives a launch pulse in cycle 1.
  - A completion flag sampled at edge N gives hi_w in cycle N+1 and done in cycle N+2.
  - Divide-by-zero: done and div_zero are high in cycle 2.
- Simultaneous events: if the completion flag and the watchdog expiry occur in the same cycle, completion wins and no timeout is raised.
- hi_data/lo_data hold their value between operations.

Optional Feature:
MULDIV_TIMEOUT_EN
- Defined: the watchdog is enabled. When the counter reaches TIMEOUT_CYCLES in RUN without a completion flag, go to ERR and raise timeout.
- Undefined: RUN waits indefinitely, timeout is tied to 0, and ERR is reachable only through divide-by-zero. The counter logic may be removed.

Test Plan:
- MULT, a=32'hFFFF_FFFF, b=2, mult_end 33 cycles after mult_start with hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFE -> hi_w/lo_w for one cycle with those values, done one cycle later, busy low afterwards.
- DIV, a=100, b=7, div_done after 32 cycles with quot=14, rem=2 -> lo_data=14, hi_data=2, done pulse, div_zero=0.
- DIV, b=0 -> no div_start; done, div_zero and unit_reset high in cycle 2; hi_w never asserts; HI/LO unchanged.
- Second start during RUN, plus a stray div_done during a MULT -> both ignored; only the first operation completes, with the mult results.
- Reset asserted in RUN cycle 10 -> IDLE next cycle, all outputs 0; a later mult_end causes no write.
- With MULDIV_TIMEOUT_EN and TIMEOUT_CYCLES=64, no completion flag -> ERR after 64 RUN cycles: timeout=1, done=1, unit_reset=1, no HI/LO write. Without the macro -> busy stays high indefinitely.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request, mult/div unit handshake and HI/LO write port of the muldiv sequencer
interface muldiv_sequencer_if;
  logic start, op;
  logic [31:0] a_in, b_in;
  logic mult_start, mult_end;
  logic [31:0] mult_hi, mult_lo;
  logic div_start, div_done;
  logic [31:0] div_quot, div_rem;
  logic unit_reset;
  logic [31:0] hi_data, lo_data;
  logic hi_w, lo_w, busy, done, div_zero, timeout;
  modport master(
    output start, op, a_in, b_in, mult_end, mult_hi, mult_lo, div_done, div_quot, div_rem,
    input mult_start, div_start, unit_reset, hi_data, lo_data, hi_w, lo_w, busy, done, div_zero, timeout
  );
  modport slave(
    input start, op, a_in, b_in, mult_end, mult_hi, mult_lo, div_done, div_quot, div_rem,
    output mult_start, div_start, unit_reset, hi_data, lo_data, hi_w, lo_w, busy, done, div_zero, timeout
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences the shared mult/div units and owns the HI/LO write port.
// Optional watchdog on the RUN state is enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 7
) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, RUN, WRITE, DONE, ERR} state_t;
  state_t r_state, w_next;
  logic r_op, r_bz, w_flag, w_expire;
  logic [31:0] r_hi, r_lo;
  if (CNT_W < $clog2(TIMEOUT_CYCLES + 1)) begin : g_bad_cnt_w
    $error("CNT_W cannot hold TIMEOUT_CYCLES");
  end
  // the unit not selected by op cannot end the RUN state
  assign w_flag = r_op ? bus.div_done : bus.mult_end;
`ifdef MULDIV_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic r_to;
  assign w_expire = !w_flag && r_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt <= '0;
      r_to <= 1'b0;
    end else begin
      r_cnt <= r_state == CHECK ? '0 : (r_state == RUN && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
      r_to <= r_state == RUN && w_next == ERR;
    end
  assign bus.timeout = r_state == ERR && r_to;
  assign bus.div_zero = r_state == ERR && !r_to;
`else
  assign w_expire = 1'b0;
  assign bus.timeout = 1'b0;
  assign bus.div_zero = r_state == ERR;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.start ? CHECK : IDLE;
      CHECK:   w_next = (r_op && r_bz) ? ERR : RUN;
      RUN:     w_next = w_flag ? WRITE : w_expire ? ERR : RUN;
      WRITE:   w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_op <= 1'b0;
      r_bz <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_op <= bus.op;
        r_bz <= bus.b_in == '0;
      end
      if (r_state == RUN && w_flag) begin
        r_hi <= r_op ? bus.div_rem : bus.mult_hi;
        r_lo <= r_op ? bus.div_quot : bus.mult_lo;
      end
    end
  assign bus.mult_start = r_state == CHECK && !r_op;
  assign bus.div_start = r_state == CHECK && r_op && !r_bz;
  assign bus.unit_reset = r_state == ERR;
  assign bus.hi_w = r_state == WRITE;
  assign bus.lo_w = r_state == WRITE;
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE || r_state == ERR;
  assign bus.hi_data = r_hi;
  assign bus.lo_data = r_lo;
endmodule
